// File: rtl/fb_scanout.sv
// Framebuffer scan-out: streams one frame from a single-port RAM to a pixel sink,
// giving pixel-writer accesses priority over scan reads.
//
// state | meaning
// IDLE  | waiting for start; only writer traffic reaches the RAM
// SCAN  | issuing reads 0..WIDTH*HEIGHT-1 whenever the output FIFO has credit
// DRAIN | all reads issued; emptying the inflight slot and the FIFO
module fb_scanout #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 17,
    parameter int WIDTH  = 320,
    parameter int HEIGHT = 240
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              busy,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ack,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              ram_w_enable,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic [DATA_W-1:0] px_data,
    output logic              px_valid,
    input  logic              px_ready,
    output logic              px_sof,
    output logic              px_eol,
    output logic              frame_done
);

    localparam int X_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int Y_W = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(WIDTH * HEIGHT - 1);
    localparam logic [X_W-1:0]    X_LAST    = X_W'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, SCAN, DRAIN} state_t;

    state_t            state;
    logic [ADDR_W-1:0] rd_addr;
    logic [X_W-1:0]    x;
    logic [Y_W-1:0]    y;
    logic              infl_v, infl_sof, infl_eol;
    logic [1:0]        count;
    logic [DATA_W-1:0] d0, d1;
    logic              s0, s1, e0, e1;
    logic              pop, push, rd_issue, last_rd;
    logic [2:0]        occ;

    assign pop      = px_valid & px_ready;
    assign push     = infl_v;
    // FIFO slots already committed next cycle; a new read needs one free slot
    assign occ      = {1'b0, count} + {2'b00, infl_v} - {2'b00, pop};
    assign rd_issue = (state == SCAN) && !wr_req && (occ < 3'd2);
    assign last_rd  = (rd_addr == LAST_ADDR);

    assign wr_ack       = wr_req;
    assign ram_w_enable = wr_req;
    assign ram_addr     = wr_req ? wr_addr : rd_addr;
    assign ram_wdata    = wr_data;

    assign busy       = (state != IDLE);
    assign px_valid   = (count != 2'd0);
    assign px_data    = d0;
    assign px_sof     = px_valid & s0;
    assign px_eol     = px_valid & e0;
    // In DRAIN every remaining pixel sits in the FIFO, so the lone entry is the last one
    assign frame_done = (state == DRAIN) && pop && (count == 2'd1) && !infl_v;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            rd_addr  <= '0;
            x        <= '0;
            y        <= '0;
            infl_v   <= 1'b0;
            infl_sof <= 1'b0;
            infl_eol <= 1'b0;
            count    <= 2'd0;
            d0       <= '0;
            d1       <= '0;
            s0       <= 1'b0;
            s1       <= 1'b0;
            e0       <= 1'b0;
            e1       <= 1'b0;
        end else begin
            case (state)
                IDLE:    if (start) state <= SCAN;
                SCAN:    if (rd_issue && last_rd) state <= DRAIN;
                DRAIN:   if (frame_done) state <= IDLE;
                default: state <= IDLE;
            endcase

            if (rd_issue) begin
                infl_sof <= (rd_addr == '0);
                infl_eol <= (x == X_LAST);
                if (last_rd) begin
                    rd_addr <= '0;
                    x       <= '0;
                    y       <= '0;
                end else begin
                    rd_addr <= rd_addr + ADDR_W'(1);
                    if (x == X_LAST) begin
                        x <= '0;
                        y <= y + Y_W'(1);
                    end else begin
                        x <= x + X_W'(1);
                    end
                end
            end
            infl_v <= rd_issue;

            case ({push, pop})
                2'b10: begin
                    if (count == 2'd0) begin
                        d0 <= ram_rdata; s0 <= infl_sof; e0 <= infl_eol;
                    end else begin
                        d1 <= ram_rdata; s1 <= infl_sof; e1 <= infl_eol;
                    end
                    count <= count + 2'd1;
                end
                2'b01: begin
                    d0 <= d1; s0 <= s1; e0 <= e1;
                    count <= count - 2'd1;
                end
                2'b11: begin
                    if (count == 2'd1) begin
                        d0 <= ram_rdata; s0 <= infl_sof; e0 <= infl_eol;
                    end else begin
                        d0 <= d1; s0 <= s1; e0 <= e1;
                        d1 <= ram_rdata; s1 <= infl_sof; e1 <= infl_eol;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fb_scanout.sv
// Scoreboard bench for fb_scanout on a 4x2 frame with a synchronous RAM model.
module tb_fb_scanout;
    localparam int DW = 8;
    localparam int AW = 8;
    localparam int W  = 4;
    localparam int H  = 2;
    localparam int N  = W * H;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic          wr_req = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [DW-1:0] wr_data = '0;
    logic          px_ready = 1'b1;
    logic          busy, wr_ack, ram_w_enable, px_valid, px_sof, px_eol, frame_done;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata, ram_rdata, px_data;

    fb_scanout #(.DATA_W(DW), .ADDR_W(AW), .WIDTH(W), .HEIGHT(H)) dut (
        .clk(clk), .reset(reset), .start(start), .busy(busy),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_w_enable(ram_w_enable),
        .ram_rdata(ram_rdata), .px_data(px_data), .px_valid(px_valid),
        .px_ready(px_ready), .px_sof(px_sof), .px_eol(px_eol), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    // RAM model, preloaded with its own address on the first clock
    logic [DW-1:0] mem [256];
    logic          loaded = 1'b0;
    always @(posedge clk) begin
        if (!loaded) begin
            for (int i = 0; i < 256; i++) mem[i] <= 8'(i);
            loaded <= 1'b1;
        end else begin
            if (ram_w_enable) mem[ram_addr] <= ram_wdata;
            ram_rdata <= mem[ram_addr];
        end
    end

    typedef struct packed {
        logic [DW-1:0] data;
        logic          sof;
        logic          eol;
        logic          done;
    } px_t;

    px_t           exp_q[$];
    logic [DW-1:0] mem_exp [256];
    int            checks = 0;
    int            failures = 0;
    int            done_cnt = 0;
    int            mode = 0;
    int            pcnt = 0;
    logic          pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // px_ready driver: 0 = always ready, 1 = 1,0,0,1 pattern, 2 = never ready
    always @(posedge clk) begin
        #1;
        case (mode)
            1:       begin px_ready = pat[pcnt]; pcnt = (pcnt + 1) % 4; end
            2:       px_ready = 1'b0;
            default: px_ready = 1'b1;
        endcase
    end

    logic          prev_stall = 1'b0;
    logic          prev_done = 1'b0;
    logic [DW-1:0] prev_data = '0;
    logic          prev_sof = 1'b0;
    logic          prev_eol = 1'b0;
    px_t           e;

    always @(negedge clk) begin
        if (prev_done && !reset) check("busy_after_done", 32'(busy), 32'(0));
        if (prev_stall && !reset)
            check("stall_hold", 32'({px_valid, px_data, px_sof, px_eol}),
                  32'({1'b1, prev_data, prev_sof, prev_eol}));
        if (frame_done) done_cnt++;
        if (px_valid && px_ready && !reset) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_pixel actual=%0h required=none", px_data);
            end else begin
                e = exp_q.pop_front();
                check("pixel", 32'({px_data, px_sof, px_eol, frame_done}),
                      32'({e.data, e.sof, e.eol, e.done}));
            end
        end
        prev_stall = px_valid & !px_ready;
        prev_data  = px_data;
        prev_sof   = px_sof;
        prev_eol   = px_eol;
        prev_done  = frame_done;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic push_frame();
        px_t p;
        for (int i = 0; i < N; i++) begin
            p.data = mem_exp[i];
            p.sof  = (i == 0);
            p.eol  = ((i % W) == W - 1);
            p.done = (i == N - 1);
            exp_q.push_back(p);
        end
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while ((busy || exp_q.size() != 0) && n < budget) begin
            tick();
            n++;
        end
        if (n >= budget) begin
            checks++;
            failures++;
            $display("FAIL timeout actual=busy%0b/pending%0d required=idle", busy, exp_q.size());
        end
        repeat (2) tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 256; i++) mem_exp[i] = 8'(i);
        repeat (3) tick();
        @(negedge clk);
        check("reset_state", 32'({busy, px_valid, px_sof, px_eol, frame_done, ram_w_enable, wr_ack}), 32'(0));
        tick();
        reset = 1'b0;
        repeat (2) tick();

        // Basic frame with latency and throughput
        push_frame();
        pulse_start();
        @(negedge clk);
        check("lat_t1", 32'({busy, px_valid, ram_w_enable, ram_addr}), 32'({1'b1, 1'b0, 1'b0, 8'd0}));
        tick();
        @(negedge clk);
        check("lat_t2", 32'({px_valid, ram_addr}), 32'({1'b0, 8'd1}));
        tick();
        @(negedge clk);
        check("lat_t3", 32'(px_valid), 32'(1));
        for (int k = 1; k < N; k++) begin
            tick();
            @(negedge clk);
            check("throughput", 32'(px_valid), 32'(1));
        end
        wait_idle(200);
        check("s1_done_cnt", 32'(done_cnt), 32'(1));

        // Back-pressure pattern
        mode = 1;
        push_frame();
        pulse_start();
        wait_idle(200);
        check("s2_done_cnt", 32'(done_cnt), 32'(2));
        mode = 0;
        tick();

        // Writer holds the RAM for 5 cycles mid-scan
        push_frame();
        pulse_start();
        repeat (2) tick();
        for (int k = 0; k < 5; k++) begin
            wr_req  = 1'b1;
            wr_addr = 8'(100 + k);
            wr_data = 8'(8'hE0 + k);
            mem_exp[100 + k] = 8'(8'hE0 + k);
            @(negedge clk);
            check("wr_mid", 32'({wr_ack, ram_w_enable, ram_addr, ram_wdata}),
                  32'({1'b1, 1'b1, 8'(100 + k), 8'(8'hE0 + k)}));
            tick();
        end
        wr_req = 1'b0;
        @(negedge clk);
        check("resume_addr", 32'({ram_w_enable, ram_addr}), 32'({1'b0, 8'd2}));
        wait_idle(200);
        check("s3_done_cnt", 32'(done_cnt), 32'(3));

        // Second start while busy is ignored
        push_frame();
        pulse_start();
        repeat (3) tick();
        pulse_start();
        wait_idle(200);
        repeat (10) tick();
        check("s4_single_done", 32'({busy, 8'(done_cnt)}), 32'({1'b0, 8'd4}));

        // Reset with two pixels buffered
        mode = 2;
        tick();
        pulse_start();
        repeat (4) tick();
        @(negedge clk);
        check("buffered", 32'({busy, px_valid}), 32'({1'b1, 1'b1}));
        reset = 1'b1;
        tick();
        @(negedge clk);
        check("reset_abort", 32'({px_valid, busy, frame_done}), 32'(0));
        tick();
        reset = 1'b0;
        mode = 0;
        exp_q.delete();
        repeat (3) tick();
        check("abort_no_done", 32'(done_cnt), 32'(4));
        push_frame();
        pulse_start();
        wait_idle(200);
        check("s5_done_cnt", 32'(done_cnt), 32'(5));

        // Write before start shows up in the next frame
        wr_req  = 1'b1;
        wr_addr = 8'd5;
        wr_data = 8'h5A;
        mem_exp[5] = 8'h5A;
        @(negedge clk);
        check("wr_idle", 32'({wr_ack, ram_w_enable, ram_addr, ram_wdata}), 32'({1'b1, 1'b1, 8'd5, 8'h5A}));
        tick();
        wr_req = 1'b0;
        tick();
        push_frame();
        pulse_start();
        wait_idle(200);
        check("s6_done_cnt", 32'(done_cnt), 32'(6));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
